interrupt_sequencer: RTL

- Arbitrates four external interrupt request lines and redirects the program sequencer to a per-line vector address.
- Saves the return address on entry and issues a return jump when the service routine executes its return-from-interrupt instruction.
- Sits beside program_sequencer. Its jump/vector outputs are ORed into the sequencer's jump inputs by the top level, and its return outputs drive the sequencer's 8-bit return path.
- One interrupt is serviced at a time; there is no nesting.

---
 rtl/interrupt_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/interrupt_sequencer.sv
// Purpose: arbitrates four rising-edge interrupt lines and steers the program
//          sequencer to a per-line vector, then back to the saved return address.
// Latency: irq edge to pending = 3 edges, pending to int_jmp = 1 edge (if
//          eligible and no branch in flight); rti to ret_jmp = 1 edge.
// Backpressure: ps_branch defers a grant cycle by cycle; requests stay latched
//          in pending until granted, so none are lost while a line is served.
//
// Ports:
//   clk, reset             clock and asynchronous active-high reset
//   irq[3:0]               asynchronous request lines (rising-edge sensitive)
//   mask_we, mask_data     mask register write (bit i = 1 enables irq[i])
//   pc                     address of the instruction currently fetched
//   ps_branch              decoder issuing jmp/jmp_nz; grant is held off
//   rti                    return-from-interrupt strobe (honoured in SERVICE only)
//   int_jmp, int_vector    one-cycle vector jump request and its upper nibble
//   ret_jmp, ret_addr      one-cycle return jump request and saved address
//   int_active, irq_id     service in progress and index of the line served
//   pending, mask          latched requests and current mask register
module interrupt_sequencer #(
    parameter logic [3:0] VEC_BASE = 4'hC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq,
    input  logic       mask_we,
    input  logic [3:0] mask_data,
    input  logic [7:0] pc,
    input  logic       ps_branch,
    input  logic       rti,
    output logic       int_jmp,
    output logic [3:0] int_vector,
    output logic       ret_jmp,
    output logic [7:0] ret_addr,
    output logic       int_active,
    output logic [1:0] irq_id,
    output logic [3:0] pending,
    output logic [3:0] mask
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_VECTOR  = 2'd1,
        S_SERVICE = 2'd2,
        S_RETURN  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] sync3;
    logic [3:0] rise;
    logic [3:0] eligible;
    logic [1:0] winner;
    logic       grant;
    logic [3:0] clr;

    // Two flops resolve metastability; the third only remembers the previous
    // synchronised level so a held-high line yields a single request.
    assign rise     = sync2 & ~sync3;
    assign eligible = pending & mask;

    // Lowest index wins: scan from the top so lower indices overwrite.
    always_comb begin
        winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = i[1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            S_IDLE: begin
                if ((eligible != 4'd0) && !ps_branch) begin
                    grant     = 1'b1;
                    state_nxt = S_VECTOR;
                end
            end
            S_VECTOR: begin
                state_nxt = S_SERVICE;
            end
            S_SERVICE: begin
                if (rti) begin
                    state_nxt = S_RETURN;
                end
            end
            S_RETURN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign clr = grant ? (4'b0001 << winner) : 4'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 4'd0;
            sync2    <= 4'd0;
            sync3    <= 4'd0;
            pending  <= 4'd0;
            mask     <= 4'd0;
            ret_addr <= 8'd0;
            irq_id   <= 2'd0;
        end else begin
            sync1   <= irq;
            sync2   <= sync1;
            sync3   <= sync2;
            // A new edge on the line being granted survives the clear.
            pending <= (pending & ~clr) | rise;
            if (mask_we) begin
                mask <= mask_data;
            end
            if (grant) begin
                irq_id   <= winner;
                ret_addr <= pc + 8'd1;
            end
        end
    end

    assign int_jmp    = (state == S_VECTOR);
    assign int_vector = (state == S_VECTOR) ? (VEC_BASE + {2'b00, irq_id}) : 4'd0;
    assign ret_jmp    = (state == S_RETURN);
    assign int_active = (state != S_IDLE);

endmodule
